// File: rtl/uart_tx_fifo_drain.sv
// UART 8N1 transmitter that pops bytes from a TX FIFO and serializes them on tx_o.
// Define UART_TX_PARITY_EN to append an even-parity bit between data and stop.
module uart_tx_fifo_drain #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tx_en_i,
    input  logic       fifo_empty_i,
    input  logic [7:0] fifo_pop_data_i,
    output logic       fifo_pop_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic       tx_done_o
);
    localparam int BIT_CYCLES = CLK_FREQ / BAUD;
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    logic          tx_q, tx_d;
    logic          pop_q, pop_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
            pop_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            pop_q   <= pop_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (tx_en_i && !fifo_empty_i) state_d = S_LOAD;
            end
            // Capture on the same edge the FIFO advances its read pointer.
            S_LOAD: begin
                data_d  = fifo_pop_data_i;
                baud_d  = '0;
                state_d = S_START;
            end
            S_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = (tx_en_i && !fifo_empty_i) ? S_LOAD : S_IDLE;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from next-state values so the registered pins line up with the state.
    always_comb begin
        tx_d   = 1'b1;
        pop_d  = 1'b0;
        busy_d = (state_d != S_IDLE);
        done_d = 1'b0;
        case (state_d)
            S_LOAD:   pop_d = 1'b1;
            S_START:  tx_d  = 1'b0;
            S_DATA:   tx_d  = data_d[bit_d];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d  = ^data_d;
`endif
            S_STOP:   done_d = (baud_d == BAUD_LAST);
            default:  tx_d  = 1'b1;
        endcase
    end

    assign fifo_pop_o = pop_q;
    assign tx_o       = tx_q;
    assign busy_o     = busy_q;
    assign tx_done_o  = done_q;

endmodule
